regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Writeback stage directly downstream of the ALU output mux.
- Latches the muxed result, write-enable, destination register and branch flag into a one-entry writeback register, then commits them to a 16 x 32 ARM-style register file and program counter on the following edge.
- Provides two combinational read ports with bypass of the pending writeback, the current PC, and a one-cycle branch_taken pulse used upstream to flush fetch/decode.

Parameters:
- DATA_WIDTH, 32, width of registers, PC and writeback data.
- NUM_REGS, 16, architectural registers R0..R15; R15 is the PC.
- PC_STEP, 4, PC increment per non-stalled cycle.
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_READ_OFFSET, 8, added to PC when R15 is read (ARM pipeline view).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_data  input  DATA_WIDTH  result from ALU output mux (ALU result or branch target).
- wb_en  input  1  writeback enable from ALU output mux (already qualified by condition check).
- wb_addr  input  4  destination register Rd.
- opcode  input  5  instruction opcode; 5'b10001 = branch.
- stall  input  1  hold: no new capture, no PC increment.
- rn_addr  input  4  read port A address.
- rm_addr  input  4  read port B address.
- rn_data  output  DATA_WIDTH  read port A data.
- rm_data  output  DATA_WIDTH  read port B data.
- pc  output  DATA_WIDTH  current program counter (R15).
- branch_taken  output  1  one-cycle pulse when PC was loaded from writeback.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: R0..R14 = 0, pc = RESET_PC, branch_taken = 0, writeback latch valid_q = 0.
- Reset asserted mid-operation discards any pending writeback. No commit occurs on the reset edge.
- Capture (edge N, !stall):
  - valid_q <= wb_en
  - addr_q <= wb_addr
  - data_q <= wb_data
  - br_q <= (opcode == 5'b10001)
- Stall: while stall = 1, the latch is not refilled; valid_q <= 0 after any pending commit.
- Commit (edge N+1, valid_q = 1), independent of stall:
  - br_q = 1: pc <= data_q (absolute target), branch_taken <= 1; addr_q ignored.
  - br_q = 0 and addr_q = 15: pc <= data_q, branch_taken <= 1.
  - Otherwise: reg[addr_q] <= data_q, branch_taken <= 0.
- Write latency: two edges from input to architectural state; zero cycles to visibility via bypass.
- PC update when no PC-load commit: pc <= pc + PC_STEP if !stall, else hold. A PC-load commit has priority over increment.
- PC arithmetic: mod 2^DATA_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
- branch_taken is high for exactly one cycle per PC-load commit. Back-to-back branches give back-to-back pulses.
- Reads (combinational, per port):
  - addr = 15: pc + PC_READ_OFFSET; no bypass from a pending R15 write.
  - valid_q && !br_q && addr == addr_q: data_q (bypass).
  - Otherwise: reg[addr].
- Both ports may address the same register and return identical data.
- wb_en = 0 captures a bubble: no register or PC change beyond the normal increment.
- A branch with wb_en = 0 (condition failed) is not taken; PC increments.

Test Plan:
- Reset then 3 idle cycles -> pc = 0, 4, 8, 12; rn_addr = 3 reads 0; rn_addr = 15 reads pc + 8; branch_taken = 0.
- wb_en = 1, wb_addr = 2, wb_data = 32'hDEAD_BEEF, opcode = 0 for one cycle -> next cycle rn_addr = 2 returns DEADBEEF via bypass; two cycles later it returns DEADBEEF from reg[2].
- opcode = 10001, wb_en = 1, wb_data = 32'h0000_0100 -> after commit pc = 0x100, branch_taken pulses for exactly one cycle, next cycle pc = 0x104.
- Same branch with wb_en = 0 -> pc keeps incrementing by 4, no pulse.
- stall = 1 for 3 cycles with a pending write to R5 = 0x55 -> R5 commits, pc frozen for 3 cycles, inputs presented during stall are ignored.
- reset asserted the cycle after capturing a write to R7 = 0x77 -> R7 reads 0, pc = RESET_PC, no branch_taken.
- pc preloaded to 0xFFFF_FFFC via a branch -> next increment gives pc = 0.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback stage: one-entry writeback latch feeding a 16 x 32 register file
// whose top entry (R15) is the program counter. Two combinational read ports
// see a pending general-register write through a bypass path; R15 reads return
// the pipelined PC view (pc + PC_READ_OFFSET) and are never bypassed.
module regfile_writeback #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_REGS       = 16,
  parameter int                    PC_STEP        = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC       = 32'h0000_0000,
  parameter int                    PC_READ_OFFSET = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_en,
  input  logic [3:0]            wb_addr,
  input  logic [4:0]            opcode,
  input  logic                  stall,
  input  logic [3:0]            rn_addr,
  input  logic [3:0]            rm_addr,
  output logic [DATA_WIDTH-1:0] rn_data,
  output logic [DATA_WIDTH-1:0] rm_data,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  branch_taken
);

  localparam int              GP_REGS   = NUM_REGS - 1;
  localparam logic [3:0]      PC_ADDR   = 4'(NUM_REGS - 1);
  localparam logic [4:0]      OP_BRANCH = 5'b10001;
  localparam logic [DATA_WIDTH-1:0] PC_INC  = DATA_WIDTH'(PC_STEP);
  localparam logic [DATA_WIDTH-1:0] PC_VIEW = DATA_WIDTH'(PC_READ_OFFSET);

  // writeback latch
  logic                  valid_q, valid_d;
  logic [3:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  br_q, br_d;

  // architectural state
  logic [DATA_WIDTH-1:0] regs_q [GP_REGS];
  logic [DATA_WIDTH-1:0] regs_d [GP_REGS];
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  branch_taken_q, branch_taken_d;

  logic                  pc_load;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] pc_read;

  // Classify the pending commit: a branch or an explicit R15 write reloads the PC,
  // anything else valid goes to the general register file.
  always_comb begin
    pc_load   = valid_q && (br_q || (addr_q == PC_ADDR));
    reg_write = valid_q && !pc_load;
  end

  // Capture a new writeback unless stalled; a stall drains the latch after its commit.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    br_d    = br_q;
    if (stall) begin
      valid_d = 1'b0;
    end else begin
      valid_d = wb_en;
      addr_d  = wb_addr;
      data_d  = wb_data;
      br_d    = (opcode == OP_BRANCH);
    end
  end

  // Commit a general-register write from the latch; commits proceed even while stalled.
  always_comb begin
    regs_d = regs_q;
    if (reg_write) begin
      regs_d[addr_q] = data_q;
    end
  end

  // PC: a load from the latch wins over the normal increment; stall freezes the increment.
  always_comb begin
    branch_taken_d = pc_load;
    if (pc_load) begin
      pc_d = data_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_INC;
    end
  end

  // State register with synchronous reset; reset drops any pending writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      br_q           <= 1'b0;
      pc_q           <= RESET_PC;
      branch_taken_q <= 1'b0;
      for (int i = 0; i < GP_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      br_q           <= br_d;
      pc_q           <= pc_d;
      branch_taken_q <= branch_taken_d;
      for (int i = 0; i < GP_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Pipelined view of R15 as seen by an instruction reading it.
  always_comb begin
    pc_read = pc_q + PC_VIEW;
  end

  // Read port A: R15 view, then bypass of a pending non-branch write, then the file.
  always_comb begin
    if (rn_addr == PC_ADDR) begin
      rn_data = pc_read;
    end else if (valid_q && !br_q && (rn_addr == addr_q)) begin
      rn_data = data_q;
    end else begin
      rn_data = regs_q[rn_addr];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    if (rm_addr == PC_ADDR) begin
      rm_data = pc_read;
    end else if (valid_q && !br_q && (rm_addr == addr_q)) begin
      rm_data = data_q;
    end else begin
      rm_data = regs_q[rm_addr];
    end
  end

  // Drive outputs from registered state.
  always_comb begin
    pc           = pc_q;
    branch_taken = branch_taken_q;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a table of one-edge vectors with
// hand-computed expectations, followed by hand-written multi-cycle sequences
// (branch commit under stall, PC wrap, reset discarding a pending write).
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [4:0]  opcode;
  logic        stall;
  logic [3:0]  rn_addr;
  logic [3:0]  rm_addr;
  logic [31:0] rn_data;
  logic [31:0] rm_data;
  logic [31:0] pc;
  logic        branch_taken;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] BR = 5'b10001;

  regfile_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .wb_data      (wb_data),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .opcode       (opcode),
    .stall        (stall),
    .rn_addr      (rn_addr),
    .rm_addr      (rm_addr),
    .rn_data      (rn_data),
    .rm_data      (rm_data),
    .pc           (pc),
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [4:0]  op;
    logic        stl;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] exp_pc;
    logic [31:0] exp_rn;
    logic [31:0] exp_rm;
    logic        exp_bt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [3:0] addr, input logic [31:0] data,
                     input logic [4:0] op, input logic stl, input logic [3:0] rn,
                     input logic [3:0] rm, input logic [31:0] e_pc, input logic [31:0] e_rn,
                     input logic [31:0] e_rm, input logic e_bt);
    vec_t v;
    v.en = en; v.addr = addr; v.data = data; v.op = op; v.stl = stl;
    v.rn = rn; v.rm = rm;
    v.exp_pc = e_pc; v.exp_rn = e_rn; v.exp_rm = e_rm; v.exp_bt = e_bt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] addr, input logic [31:0] data,
                       input logic [4:0] op, input logic stl, input logic [3:0] rn,
                       input logic [3:0] rm);
    wb_en = en; wb_addr = addr; wb_data = data; opcode = op; stall = stl;
    rn_addr = rn; rm_addr = rm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each vector: drive inputs, take one rising edge, then expect outputs.
    //   en  addr   data           op    stl rn  rm    pc            rn            rm            bt
    add(0, 4'd0,  32'h0,         5'd0, 0,  3,  15,   32'h4,        32'h0,        32'hC,        0); // idle
    add(0, 4'd0,  32'h0,         5'd0, 0,  3,  15,   32'h8,        32'h0,        32'h10,       0);
    add(0, 4'd0,  32'h0,         5'd0, 0,  3,  15,   32'hC,        32'h0,        32'h14,       0);
    add(1, 4'd2,  32'hDEAD_BEEF, 5'd0, 0,  2,  2,    32'h10,       32'hDEAD_BEEF,32'hDEAD_BEEF,0); // bypass
    add(0, 4'd0,  32'h0,         5'd0, 0,  2,  3,    32'h14,       32'hDEAD_BEEF,32'h0,        0); // committed
    add(0, 4'd0,  32'h0,         5'd0, 0,  2,  15,   32'h18,       32'hDEAD_BEEF,32'h20,       0);
    add(1, 4'd3,  32'h100,       BR,   0,  3,  15,   32'h1C,       32'h0,        32'h24,       0); // branch captured, no bypass
    add(0, 4'd0,  32'h0,         5'd0, 0,  3,  15,   32'h100,      32'h0,        32'h108,      1); // branch taken
    add(0, 4'd0,  32'h0,         5'd0, 0,  3,  15,   32'h104,      32'h0,        32'h10C,      0);
    add(0, 4'd0,  32'h200,       BR,   0,  3,  15,   32'h108,      32'h0,        32'h110,      0); // failed branch
    add(0, 4'd0,  32'h0,         5'd0, 0,  3,  15,   32'h10C,      32'h0,        32'h114,      0);
    add(1, 4'd15, 32'h400,       5'd0, 0,  15, 15,   32'h110,      32'h118,      32'h118,      0); // R15 write, no bypass
    add(0, 4'd0,  32'h0,         5'd0, 0,  15, 15,   32'h400,      32'h408,      32'h408,      1);
    add(1, 4'd0,  32'h500,       BR,   0,  15, 2,    32'h404,      32'h40C,      32'hDEAD_BEEF,0); // back-to-back branches
    add(1, 4'd0,  32'h600,       BR,   0,  15, 2,    32'h500,      32'h508,      32'hDEAD_BEEF,1);
    add(0, 4'd0,  32'h0,         5'd0, 0,  15, 2,    32'h600,      32'h608,      32'hDEAD_BEEF,1);
    add(0, 4'd0,  32'h0,         5'd0, 0,  15, 2,    32'h604,      32'h60C,      32'hDEAD_BEEF,0);
    add(1, 4'd5,  32'h55,        5'd0, 0,  5,  15,   32'h608,      32'h55,       32'h610,      0); // R5 captured
    add(1, 4'd6,  32'h66,        5'd0, 1,  5,  6,    32'h608,      32'h55,       32'h0,        0); // stall: commit, ignore input
    add(1, 4'd6,  32'h66,        5'd0, 1,  5,  6,    32'h608,      32'h55,       32'h0,        0);
    add(1, 4'd6,  32'h66,        BR,   1,  5,  6,    32'h608,      32'h55,       32'h0,        0);
    add(0, 4'd0,  32'h0,         5'd0, 0,  5,  6,    32'h60C,      32'h55,       32'h0,        0);
    add(1, 4'd1,  32'h1111_1111, 5'd0, 0,  1,  2,    32'h610,      32'h1111_1111,32'hDEAD_BEEF,0);
    add(0, 4'd0,  32'h0,         5'd0, 0,  1,  2,    32'h614,      32'h1111_1111,32'hDEAD_BEEF,0);

    reset = 1'b1;
    drive(0, 4'd0, 32'h0, 5'd0, 0, 4'd3, 4'd15);
    tick();
    tick();
    check("reset_pc", pc, 32'h0);
    check("reset_bt", {31'b0, branch_taken}, 32'h0);
    check("reset_rn", rn_data, 32'h0);
    check("reset_rm_r15", rm_data, 32'h8);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].op, vecs[i].stl,
            vecs[i].rn, vecs[i].rm);
      tick();
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_rn", i), rn_data, vecs[i].exp_rn);
      check($sformatf("v%0d_rm", i), rm_data, vecs[i].exp_rm);
      check($sformatf("v%0d_bt", i), {31'b0, branch_taken}, {31'b0, vecs[i].exp_bt});
    end

    // Branch commit lands while stalled.
    drive(1, 4'd0, 32'h800, BR, 0, 4'd15, 4'd15);
    tick();
    check("stbr_cap_pc", pc, 32'h618);
    drive(0, 4'd0, 32'h0, 5'd0, 1, 4'd15, 4'd15);
    tick();
    check("stbr_pc", pc, 32'h800);
    check("stbr_bt", {31'b0, branch_taken}, 32'h1);
    tick();
    check("stbr_hold_pc", pc, 32'h800);
    check("stbr_hold_bt", {31'b0, branch_taken}, 32'h0);
    drive(0, 4'd0, 32'h0, 5'd0, 0, 4'd15, 4'd15);
    tick();
    check("stbr_run_pc", pc, 32'h804);

    // PC wrap at the top of the address space.
    drive(1, 4'd0, 32'hFFFF_FFFC, BR, 0, 4'd15, 4'd15);
    tick();
    check("wrap_cap_pc", pc, 32'h808);
    drive(0, 4'd0, 32'h0, 5'd0, 0, 4'd15, 4'd15);
    tick();
    check("wrap_load_pc", pc, 32'hFFFF_FFFC);
    check("wrap_load_bt", {31'b0, branch_taken}, 32'h1);
    check("wrap_r15_view", rn_data, 32'h4);
    tick();
    check("wrap_pc", pc, 32'h0);
    check("wrap_bt", {31'b0, branch_taken}, 32'h0);
    check("wrap_r15_after", rn_data, 32'h8);

    // Reset right after capturing a write to R7 discards it.
    drive(1, 4'd7, 32'h77, 5'd0, 0, 4'd7, 4'd5);
    tick();
    check("r7_bypass", rn_data, 32'h77);
    check("r7_cap_pc", pc, 32'h4);
    reset = 1'b1;
    drive(0, 4'd0, 32'h0, 5'd0, 0, 4'd7, 4'd5);
    tick();
    check("rst_r7", rn_data, 32'h0);
    check("rst_r5", rm_data, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_bt", {31'b0, branch_taken}, 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_r7", rn_data, 32'h0);
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_bt", {31'b0, branch_taken}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
